// File: rtl/host_req_tagger.sv
// Host request tagger: allocates transaction tags to per-stream line reads,
// issues tagged host commands and routes (possibly out-of-order) returned data back to its stream.
module host_req_tagger #(
  parameter int addr_width       = 64,
  parameter int cache_line       = 128,
  parameter int cache_line_width = $clog2(cache_line),
  parameter int nstrms           = 64,
  parameter int nstrms_width     = $clog2(nstrms),
  parameter int ntags            = 16,
  parameter int tag_width        = $clog2(ntags),
  parameter int data_width       = 8 * cache_line
) (
  input  logic                    clk1x,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  input  logic [addr_width-1:0]   i_req_ea,
  output logic                    o_cmd_v,
  input  logic                    o_cmd_r,
  output logic [tag_width-1:0]    o_cmd_tag,
  output logic [addr_width-1:0]   o_cmd_ea,
  input  logic                    i_dat_v,
  output logic                    i_dat_r,
  input  logic [tag_width-1:0]    i_dat_tag,
  input  logic [data_width-1:0]   i_dat_d,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [data_width-1:0]   o_rsp_d,
  output logic [tag_width:0]      o_outstanding,
  output logic                    o_err
);

  logic [ntags-1:0]        inflight_q, inflight_d;
  logic [nstrms_width-1:0] sid_tbl_q [ntags];
  logic [nstrms_width-1:0] sid_tbl_d [ntags];
  logic                    cmd_v_q, cmd_v_d;
  logic [tag_width-1:0]    cmd_tag_q, cmd_tag_d;
  logic [addr_width-1:0]   cmd_ea_q, cmd_ea_d;
  logic                    rsp_v_q, rsp_v_d;
  logic [nstrms_width-1:0] rsp_sid_q, rsp_sid_d;
  logic [data_width-1:0]   rsp_d_q, rsp_d_d;
  logic [tag_width:0]      outstanding_q, outstanding_d;
  logic                    err_q, err_d;

  logic                    any_free;
  logic [tag_width-1:0]    free_tag;
  logic                    req_acc;
  logic                    dat_acc;
  logic                    dat_hit;

  // Lowest free tag comes from the registered bitmap only, so a tag released
  // this cycle cannot be handed out again until the next one.
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    for (int i = ntags - 1; i >= 0; i--) begin
      if (!inflight_q[i]) begin
        any_free = 1'b1;
        free_tag = tag_width'(i);
      end
    end
  end

  assign i_req_r = any_free && (!cmd_v_q || o_cmd_r);
  assign i_dat_r = !rsp_v_q || o_rsp_r;
  assign req_acc = i_req_v && i_req_r;
  assign dat_acc = i_dat_v && i_dat_r;
  assign dat_hit = dat_acc && inflight_q[i_dat_tag];

  always_comb begin
    inflight_d    = inflight_q;
    sid_tbl_d     = sid_tbl_q;
    cmd_v_d       = cmd_v_q;
    cmd_tag_d     = cmd_tag_q;
    cmd_ea_d      = cmd_ea_q;
    rsp_v_d       = rsp_v_q;
    rsp_sid_d     = rsp_sid_q;
    rsp_d_d       = rsp_d_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    if (cmd_v_q && o_cmd_r) cmd_v_d = 1'b0;
    if (req_acc) begin
      inflight_d[free_tag] = 1'b1;
      sid_tbl_d[free_tag]  = i_req_sid;
      cmd_v_d              = 1'b1;
      cmd_tag_d            = free_tag;
      cmd_ea_d             = {i_req_ea[addr_width-1:cache_line_width], {cache_line_width{1'b0}}};
    end

    // Data for a tag not in flight is dropped and flagged; the allocated and
    // released tags in one cycle are always distinct, so both updates can apply.
    if (rsp_v_q && o_rsp_r) rsp_v_d = 1'b0;
    if (dat_acc) begin
      if (inflight_q[i_dat_tag]) begin
        inflight_d[i_dat_tag] = 1'b0;
        rsp_v_d               = 1'b1;
        rsp_sid_d             = sid_tbl_q[i_dat_tag];
        rsp_d_d               = i_dat_d;
      end else begin
        err_d = 1'b1;
      end
    end

    if (req_acc && !dat_hit) outstanding_d = outstanding_q + 1'b1;
    else if (!req_acc && dat_hit) outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge clk1x or negedge reset) begin
    if (!reset) begin
      inflight_q    <= '0;
      sid_tbl_q     <= '{default: '0};
      cmd_v_q       <= 1'b0;
      cmd_tag_q     <= '0;
      cmd_ea_q      <= '0;
      rsp_v_q       <= 1'b0;
      rsp_sid_q     <= '0;
      rsp_d_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      sid_tbl_q     <= sid_tbl_d;
      cmd_v_q       <= cmd_v_d;
      cmd_tag_q     <= cmd_tag_d;
      cmd_ea_q      <= cmd_ea_d;
      rsp_v_q       <= rsp_v_d;
      rsp_sid_q     <= rsp_sid_d;
      rsp_d_q       <= rsp_d_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign o_cmd_v       = cmd_v_q;
  assign o_cmd_tag     = cmd_tag_q;
  assign o_cmd_ea      = cmd_ea_q;
  assign o_rsp_v       = rsp_v_q;
  assign o_rsp_sid     = rsp_sid_q;
  assign o_rsp_d       = rsp_d_q;
  assign o_outstanding = outstanding_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_host_req_tagger.sv
// Directed self-checking bench for host_req_tagger: allocation order, out-of-order
// returns, response backpressure, stray-tag error and mid-operation reset.
module tb_host_req_tagger;

  logic          clk1x = 1'b0;
  logic          reset = 1'b0;
  logic          i_req_v = 1'b0;
  logic          i_req_r;
  logic [5:0]    i_req_sid = '0;
  logic [63:0]   i_req_ea = '0;
  logic          o_cmd_v;
  logic          o_cmd_r = 1'b0;
  logic [3:0]    o_cmd_tag;
  logic [63:0]   o_cmd_ea;
  logic          i_dat_v = 1'b0;
  logic          i_dat_r;
  logic [3:0]    i_dat_tag = '0;
  logic [1023:0] i_dat_d = '0;
  logic          o_rsp_v;
  logic          o_rsp_r = 1'b0;
  logic [5:0]    o_rsp_sid;
  logic [1023:0] o_rsp_d;
  logic [4:0]    o_outstanding;
  logic          o_err;

  int testsRun = 0;
  int testsFailed = 0;

  host_req_tagger dut (
    .clk1x(clk1x), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_cmd_v(o_cmd_v), .o_cmd_r(o_cmd_r), .o_cmd_tag(o_cmd_tag), .o_cmd_ea(o_cmd_ea),
    .i_dat_v(i_dat_v), .i_dat_r(i_dat_r), .i_dat_tag(i_dat_tag), .i_dat_d(i_dat_d),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid), .o_rsp_d(o_rsp_d),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 clk1x = ~clk1x;

  function automatic logic [1023:0] lineOf(input logic [7:0] b);
    return {128{b}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk1x);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] sid, input logic [63:0] ea);
    i_req_v   = 1'b1;
    i_req_sid = sid;
    i_req_ea  = ea;
  endtask

  task automatic returnData(input logic [3:0] tag, input logic [7:0] b);
    i_dat_v   = 1'b1;
    i_dat_tag = tag;
    i_dat_d   = lineOf(b);
  endtask

  int retTag [4] = '{3, 0, 2, 1};
  int retSid [4] = '{13, 10, 12, 11};

  initial begin
    // Reset values
    #12;
    checkOutput("rst_cmd_v", 64'(o_cmd_v), 64'd0);
    checkOutput("rst_rsp_v", 64'(o_rsp_v), 64'd0);
    checkOutput("rst_err", 64'(o_err), 64'd0);
    checkOutput("rst_outstanding", 64'(o_outstanding), 64'd0);
    checkOutput("rst_cmd_ea", o_cmd_ea, 64'd0);
    tick();
    reset = 1'b1;
    checkOutput("rst_req_r", 64'(i_req_r), 64'd1);
    checkOutput("rst_dat_r", 64'(i_dat_r), 64'd1);

    // Single request/response
    applyStimulus(6'd5, 64'h1000_007F);
    tick();
    i_req_v = 1'b0;
    checkOutput("t1_cmd_v", 64'(o_cmd_v), 64'd1);
    checkOutput("t1_cmd_tag", 64'(o_cmd_tag), 64'd0);
    checkOutput("t1_cmd_ea", o_cmd_ea, 64'h1000_0000);
    checkOutput("t1_outstanding", 64'(o_outstanding), 64'd1);
    o_cmd_r = 1'b1;
    tick();
    checkOutput("t1_cmd_v_clr", 64'(o_cmd_v), 64'd0);
    returnData(4'd0, 8'hA5);
    tick();
    i_dat_v = 1'b0;
    checkOutput("t1_rsp_v", 64'(o_rsp_v), 64'd1);
    checkOutput("t1_rsp_sid", 64'(o_rsp_sid), 64'd5);
    checkOutput("t1_rsp_d", 64'(o_rsp_d == lineOf(8'hA5)), 64'd1);
    checkOutput("t1_outstanding0", 64'(o_outstanding), 64'd0);
    o_rsp_r = 1'b1;
    tick();
    checkOutput("t1_rsp_v_clr", 64'(o_rsp_v), 64'd0);

    // Sixteen back-to-back requests fill the pool
    for (int i = 0; i < 16; i++) begin
      applyStimulus(6'(i), 64'(i * 128 + i));
      tick();
      checkOutput($sformatf("t2_tag%0d", i), 64'(o_cmd_tag), 64'(i));
      checkOutput($sformatf("t2_ea%0d", i), o_cmd_ea, 64'(i * 128));
    end
    checkOutput("t2_outstanding16", 64'(o_outstanding), 64'd16);
    applyStimulus(6'd20, 64'h2000);
    returnData(4'd7, 8'h07);
    checkOutput("t2_req_r_full", 64'(i_req_r), 64'd0);
    tick();
    i_dat_v = 1'b0;
    checkOutput("t2_rsp_sid7", 64'(o_rsp_sid), 64'd7);
    checkOutput("t2_outstanding15", 64'(o_outstanding), 64'd15);
    checkOutput("t2_req_r_free", 64'(i_req_r), 64'd1);
    tick();
    i_req_v = 1'b0;
    checkOutput("t2_realloc_tag", 64'(o_cmd_tag), 64'd7);
    checkOutput("t2_realloc_v", 64'(o_cmd_v), 64'd1);
    checkOutput("t2_outstanding16b", 64'(o_outstanding), 64'd16);
    for (int i = 0; i < 16; i++) begin
      returnData(4'(i), 8'(i));
      checkOutput($sformatf("t2_dat_r%0d", i), 64'(i_dat_r), 64'd1);
      tick();
      checkOutput($sformatf("t2_drain_sid%0d", i), 64'(o_rsp_sid), (i == 7) ? 64'd20 : 64'(i));
    end
    i_dat_v = 1'b0;
    tick();
    checkOutput("t2_outstanding0", 64'(o_outstanding), 64'd0);

    // Out-of-order return
    for (int k = 0; k < 4; k++) begin
      applyStimulus(6'(10 + k), 64'(k * 128));
      tick();
    end
    i_req_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      returnData(4'(retTag[k]), 8'(8'h40 + k));
      tick();
      checkOutput($sformatf("t3_rsp_v%0d", k), 64'(o_rsp_v), 64'd1);
      checkOutput($sformatf("t3_rsp_sid%0d", k), 64'(o_rsp_sid), 64'(retSid[k]));
    end
    i_dat_v = 1'b0;
    tick();

    // Response backpressure with two returns pending
    applyStimulus(6'd30, 64'h100);
    tick();
    applyStimulus(6'd31, 64'h180);
    tick();
    i_req_v = 1'b0;
    o_rsp_r = 1'b0;
    returnData(4'd1, 8'h11);
    tick();
    returnData(4'd0, 8'h22);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("t4_dat_r_blk%0d", c), 64'(i_dat_r), 64'd0);
      tick();
      checkOutput($sformatf("t4_hold_sid%0d", c), 64'(o_rsp_sid), 64'd31);
      checkOutput($sformatf("t4_hold_d%0d", c), 64'(o_rsp_d == lineOf(8'h11)), 64'd1);
    end
    o_rsp_r = 1'b1;
    tick();
    i_dat_v = 1'b0;
    checkOutput("t4_second_v", 64'(o_rsp_v), 64'd1);
    checkOutput("t4_second_sid", 64'(o_rsp_sid), 64'd30);
    checkOutput("t4_second_d", 64'(o_rsp_d == lineOf(8'h22)), 64'd1);
    tick();
    checkOutput("t4_drained", 64'(o_rsp_v), 64'd0);
    checkOutput("t4_outstanding0", 64'(o_outstanding), 64'd0);

    // Data on never-allocated tag
    returnData(4'd9, 8'hFF);
    tick();
    i_dat_v = 1'b0;
    checkOutput("t5_no_rsp", 64'(o_rsp_v), 64'd0);
    checkOutput("t5_err", 64'(o_err), 64'd1);
    applyStimulus(6'd3, 64'h300);
    tick();
    i_req_v = 1'b0;
    checkOutput("t5_tag", 64'(o_cmd_tag), 64'd0);
    returnData(4'd0, 8'h33);
    tick();
    i_dat_v = 1'b0;
    checkOutput("t5_rsp_sid", 64'(o_rsp_sid), 64'd3);
    checkOutput("t5_err_sticky", 64'(o_err), 64'd1);
    tick();

    // Reset with four tags in flight and a pending command
    for (int k = 0; k < 4; k++) begin
      applyStimulus(6'(k + 1), 64'(k * 128 + 64'h5000));
      tick();
    end
    i_req_v = 1'b0;
    checkOutput("t6_pre_outstanding", 64'(o_outstanding), 64'd4);
    checkOutput("t6_pre_cmd_v", 64'(o_cmd_v), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_cmd_v", 64'(o_cmd_v), 64'd0);
    checkOutput("t6_cmd_tag", 64'(o_cmd_tag), 64'd0);
    checkOutput("t6_cmd_ea", o_cmd_ea, 64'd0);
    checkOutput("t6_outstanding", 64'(o_outstanding), 64'd0);
    checkOutput("t6_err", 64'(o_err), 64'd0);
    checkOutput("t6_rsp_sid", 64'(o_rsp_sid), 64'd0);
    tick();
    reset = 1'b1;
    applyStimulus(6'd9, 64'h9000);
    tick();
    i_req_v = 1'b0;
    checkOutput("t6_first_tag", 64'(o_cmd_tag), 64'd0);
    returnData(4'd2, 8'h77);
    tick();
    i_dat_v = 1'b0;
    checkOutput("t6_stale_err", 64'(o_err), 64'd1);
    checkOutput("t6_stale_no_rsp", 64'(o_rsp_v), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/host_req_tagger.md
# host_req_tagger

Host-side responder for the multi-stream buffer's host request/response interface. Accepts per-stream cache-line read requests (stream id plus effective address), assigns each a transaction tag from a free pool, and issues tagged commands to the host memory port. Returned host data, which may arrive out of order, is matched back to its stream id and delivered as a response with the cache-line payload. Sits between the buffer's host request/response ports and the host link.

## Interface

- addr_width, 64, host effective address width in bits
- cache_line, 128, host cache line size in bytes
- cache_line_width, $clog2(cache_line), byte-offset bits within a line
- nstrms, 64, number of streams
- nstrms_width, $clog2(nstrms), stream id width
- ntags, 16, maximum outstanding host transactions (power of two, >= 2)
- tag_width, $clog2(ntags), tag width
- data_width, 8*cache_line, payload width per response
- clk1x  input  1  sole clock; all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset); one clock, asynchronous active-low reset is a fixed decision
- i_req_v / i_req_r  input / output  1 / 1  request handshake from buffer
- i_req_sid  input  nstrms_width  requesting stream
- i_req_ea  input  addr_width  line address
- o_cmd_v / o_cmd_r  output / input  1 / 1  host command handshake
- o_cmd_tag  output  tag_width  allocated tag
- o_cmd_ea  output  addr_width  line-aligned address
- i_dat_v / i_dat_r  input / output  1 / 1  host data return handshake
- i_dat_tag  input  tag_width  tag of returned line
- i_dat_d  input  data_width  line payload
- o_rsp_v / o_rsp_r  output / input  1 / 1  response handshake to buffer
- o_rsp_sid  output  nstrms_width  stream owning the line
- o_rsp_d  output  data_width  line payload
- o_outstanding  output  tag_width+1  number of in-flight tags
- o_err  output  1  sticky: data returned on a tag not in flight

## Operation

- State: inflight[ntags] bitmap, sid table (ntags x nstrms_width), one-entry command register, one-entry response register, outstanding counter, error flag.
- Allocation: tag = lowest index with inflight=0, computed from registered bitmap only. i_req_r = (any free tag) && (!o_cmd_v || o_cmd_r).
- Request accept (i_req_v && i_req_r): inflight[tag]<=1, sid_table[tag]<=i_req_sid, command register loads {tag, ea with low cache_line_width bits cleared}, o_cmd_v<=1.
- Command holds stable while o_cmd_v && !o_cmd_r; o_cmd_v clears on o_cmd_r unless a new request is accepted the same cycle.
- Data return: i_dat_r = !o_rsp_v || o_rsp_r. On accept with inflight[i_dat_tag]=1: response register loads {sid_table[i_dat_tag], i_dat_d}, o_rsp_v<=1, inflight[i_dat_tag]<=0.
- On accept with inflight[i_dat_tag]=0: payload dropped, no response, o_err<=1 (cleared only by reset).
- Tag freed on cycle N is allocatable from cycle N+1, never in cycle N.
- o_outstanding: +1 on request accept, -1 on valid data accept, unchanged when both occur same cycle; equals popcount(inflight) at all times.
- Full: all ntags in flight -> i_req_r=0; data return path unaffected (no deadlock).

## Timing

- Reset values: o_cmd_v=0, o_rsp_v=0, o_err=0, o_outstanding=0, inflight=0; o_cmd_tag/o_cmd_ea/o_rsp_sid/o_rsp_d=0. i_req_r=1 and i_dat_r=1 after reset deassertion.
- Request to o_cmd_v: 1 cycle. Data accept to o_rsp_v: 1 cycle.
- Full throughput: one request and one response per cycle concurrently under constant ready.
- All outputs registered except i_req_r, i_dat_r (combinational from registered state and o_cmd_r/o_rsp_r).
- Valid/ready: data stable while v && !r; v never withdrawn before handshake.
- Reset assertion mid-operation: all state clears immediately; in-flight tags discarded; host data arriving after reset for old tags raises o_err.

## Test plan

- Single request sid=5, ea=0x1000_007F -> o_cmd_v next cycle, tag 0, ea 0x1000_0000; return tag 0 data 0xA5.. -> o_rsp_sid=5, o_rsp_d=0xA5.., o_outstanding 1->0.
- 16 back-to-back requests, o_cmd_r=1, no returns -> tags 0..15 in order, i_req_r=0 after 16th, o_outstanding=16; return tag 7 -> next request gets tag 7 one cycle later.
- Out-of-order return of tags 3,0,2,1 for sids 10,11,12,13 -> responses sids 13,10,12,11 in that order.
- o_rsp_r held 0 for 5 cycles with two returns pending -> first response stable, i_dat_r=0 while full, second delivered after release, no loss.
- Data on never-allocated tag 9 -> no o_rsp_v, o_err=1 and stays 1; later normal traffic unaffected.
- Assert reset with 4 tags in flight and o_cmd_v=1 -> all outputs zero within the cycle, o_outstanding=0, first post-reset request gets tag 0.
